msrv32_bus_arbiter: RTL and testbench

- Shares one AHB-Lite-style master port between the core's instruction-fetch requester and its load/store requester.
- Sits between the msrv32 core ports (imaddr / dmaddr / dmdata / dmwr_mask) and the single memory bus.
- Sequences address and data phases, applies data-priority arbitration with an instruction anti-starvation limit, and returns per-requester ready, read data and error.

---
 rtl/msrv32_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_msrv32_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_bus_arbiter.sv
// msrv32_bus_arbiter: shares one AHB-Lite-style master port between the
// instruction-fetch and load/store requesters of the msrv32 core.
//
// Ports
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, sync active-high reset
//   i_req_in, i_addr_in                        : fetch request (held until ready)
//   i_ready_out, i_rdata_out, i_err_out        : fetch completion pulse, data, error
//   d_req_in, d_wr_in, d_addr_in,
//   d_wmask_in, d_wdata_in                     : load/store request (held until ready)
//   d_ready_out, d_rdata_out, d_err_out        : data completion pulse, data, error
//   haddr_out, htrans_out, hwrite_out,
//   hwmask_out, hwdata_out                     : bus master outputs
//   hready_in, hrdata_in, hresp_in             : bus slave responses
//   grant_data_out                             : last grant went to the data side
//   stall_cycles_out                           : wait-state counter
//
// Optional: define MSRV32_ARB_PERF_EN to build the wait-state counter;
// otherwise stall_cycles_out is tied to zero.

module msrv32_bus_arbiter #(
    parameter int         STARVE_LIMIT  = 4,
    parameter logic [1:0] HTRANS_IDLE   = 2'b00,
    parameter logic [1:0] HTRANS_NONSEQ = 2'b10
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_ready_out,
    output logic [31:0] i_rdata_out,
    output logic        i_err_out,
    input  logic        d_req_in,
    input  logic        d_wr_in,
    input  logic [31:0] d_addr_in,
    input  logic [3:0]  d_wmask_in,
    input  logic [31:0] d_wdata_in,
    output logic        d_ready_out,
    output logic [31:0] d_rdata_out,
    output logic        d_err_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [3:0]  hwmask_out,
    output logic [31:0] hwdata_out,
    input  logic        hready_in,
    input  logic [31:0] hrdata_in,
    input  logic        hresp_in,
    output logic        grant_data_out,
    output logic [31:0] stall_cycles_out
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DPH_I = 2'd1,
        DPH_D = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  starve_cnt;
    logic [31:0] hwdata_q;
    logic        grant_data_q;

    logic bus_free;
    logic cmp_i;
    logic cmp_d;
    logic elig_i;
    logic elig_d;
    logic gnt_i;
    logic gnt_d;

    // Reset suppresses every combinational effect so an abandoned transfer
    // produces neither a completion pulse nor a new address phase.
    always_comb begin
        bus_free = !ms_riscv32_mp_rst_in &&
                   ((state == IDLE) || hready_in);
        cmp_i    = !ms_riscv32_mp_rst_in &&
                   (state == DPH_I) && hready_in;
        cmp_d    = !ms_riscv32_mp_rst_in &&
                   (state == DPH_D) && hready_in;
        // A completing requester is only eligible again next cycle.
        elig_i   = i_req_in && !cmp_i;
        elig_d   = d_req_in && !cmp_d;
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        if (bus_free) begin
            if (elig_i && elig_d) begin
                if (starve_cnt == LIMIT) begin
                    gnt_i = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_i = elig_i;
                gnt_d = elig_d;
            end
        end
    end

    always_comb begin
        haddr_out  = 32'h0;
        htrans_out = HTRANS_IDLE;
        hwrite_out = 1'b0;
        hwmask_out = 4'h0;
        unique case (1'b1)
            gnt_i: begin
                haddr_out  = i_addr_in;
                htrans_out = HTRANS_NONSEQ;
            end
            gnt_d: begin
                haddr_out  = d_addr_in;
                htrans_out = HTRANS_NONSEQ;
                hwrite_out = d_wr_in;
                hwmask_out = d_wr_in ? d_wmask_in : 4'h0;
            end
            default: ;
        endcase
    end

    assign i_ready_out    = cmp_i;
    assign i_rdata_out    = cmp_i ? hrdata_in : 32'h0;
    assign i_err_out      = cmp_i && hresp_in;
    assign d_ready_out    = cmp_d;
    assign d_rdata_out    = cmp_d ? hrdata_in : 32'h0;
    assign d_err_out      = cmp_d && hresp_in;
    assign hwdata_out     = hwdata_q;
    assign grant_data_out = grant_data_q;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state        <= IDLE;
            starve_cnt   <= 4'h0;
            hwdata_q     <= 32'h0;
            grant_data_q <= 1'b0;
        end else begin
            if (gnt_i) begin
                state        <= DPH_I;
                grant_data_q <= 1'b0;
            end else if (gnt_d) begin
                state        <= DPH_D;
                grant_data_q <= 1'b1;
            end else if (bus_free) begin
                state <= IDLE;
            end

            // Store data lives exactly as long as its data phase.
            if (gnt_d && d_wr_in) begin
                hwdata_q <= d_wdata_in;
            end else if (bus_free) begin
                hwdata_q <= 32'h0;
            end

            if (gnt_d && i_req_in) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'h1;
                end
            end else if (gnt_i || !i_req_in) begin
                starve_cnt <= 4'h0;
            end
        end
    end

`ifdef MSRV32_ARB_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            stall_q <= 32'h0;
        end else if ((state != IDLE) && !hready_in) begin
            stall_q <= stall_q + 32'h1;
        end
    end

    assign stall_cycles_out = stall_q;
`else
    assign stall_cycles_out = 32'h0;
`endif

endmodule

// File: tb/tb_msrv32_bus_arbiter.sv
// tb_msrv32_bus_arbiter: directed and randomized bench for the bus arbiter,
// compared every cycle against a transaction-level model.

module tb_msrv32_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [3:0]  hwmask;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;
    logic        grant_data;
    logic [31:0] stall;

    always #5 clk = ~clk;

    msrv32_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .i_req_in(i_req),
        .i_addr_in(i_addr),
        .i_ready_out(i_ready),
        .i_rdata_out(i_rdata),
        .i_err_out(i_err),
        .d_req_in(d_req),
        .d_wr_in(d_wr),
        .d_addr_in(d_addr),
        .d_wmask_in(d_wmask),
        .d_wdata_in(d_wdata),
        .d_ready_out(d_ready),
        .d_rdata_out(d_rdata),
        .d_err_out(d_err),
        .haddr_out(haddr),
        .htrans_out(htrans),
        .hwrite_out(hwrite),
        .hwmask_out(hwmask),
        .hwdata_out(hwdata),
        .hready_in(hready),
        .hrdata_in(hrdata),
        .hresp_in(hresp),
        .grant_data_out(grant_data),
        .stall_cycles_out(stall)
    );

    int tests = 0;
    int fails = 0;

    // Model: which requester owns the outstanding data phase (0 none,
    // 1 fetch, 2 data), whether it is a store and its data, the run of
    // data grants taken while a fetch waited, the last grant, wait cycles.
    int          m_owner;
    bit          m_store;
    logic [31:0] m_wdata;
    int          m_starve;
    bit          m_gd;
    logic [31:0] m_stall;

    logic [31:0] o_haddr;
    logic [31:0] o_hwdata;
    logic [1:0]  o_htrans;
    logic        o_hwrite;
    logic [3:0]  o_hwmask;
    logic        o_i_ready;
    logic [31:0] o_i_rdata;
    logic        o_i_err;
    logic        o_d_ready;
    logic [31:0] o_d_err_rdata;
    logic        o_d_err;
    logic        o_gd;
    logic [31:0] o_stall;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit          done_i;
        bit          done_d;
        bit          want_i;
        bit          want_d;
        bit          g_i;
        bit          g_d;
        bit          free;
        logic [31:0] e_addr;
        logic [31:0] e_stall;
        @(negedge clk);
        free   = !rst && (m_owner == 0 || hready);
        done_i = !rst && m_owner == 1 && hready;
        done_d = !rst && m_owner == 2 && hready;
        want_i = i_req && !done_i;
        want_d = d_req && !done_d;
        g_i = 1'b0;
        g_d = 1'b0;
        if (free) begin
            if (want_i && want_d) begin
                if (m_starve == LIMIT) g_i = 1'b1;
                else g_d = 1'b1;
            end else begin
                g_i = want_i;
                g_d = want_d;
            end
        end
        e_addr = g_i ? i_addr : (g_d ? d_addr : 32'h0);
        chk("htrans", 32'(htrans), (g_i || g_d) ? 32'd2 : 32'd0);
        chk("haddr", haddr, e_addr);
        chk("hwrite", 32'(hwrite), 32'(g_d && d_wr));
        chk("hwmask", 32'(hwmask), (g_d && d_wr) ? 32'(d_wmask) : 32'h0);
        chk("i_ready", 32'(i_ready), 32'(done_i));
        chk("i_rdata", i_rdata, done_i ? hrdata : 32'h0);
        chk("i_err", 32'(i_err), 32'(done_i && hresp));
        chk("d_ready", 32'(d_ready), 32'(done_d));
        chk("d_rdata", d_rdata, done_d ? hrdata : 32'h0);
        chk("d_err", 32'(d_err), 32'(done_d && hresp));
        if (!rst) begin
`ifdef MSRV32_ARB_PERF_EN
            e_stall = m_stall;
`else
            e_stall = 32'h0;
`endif
            chk("hwdata", hwdata,
                (m_owner == 2 && m_store) ? m_wdata : 32'h0);
            chk("grant_data", 32'(grant_data), 32'(m_gd));
            chk("stall", stall, e_stall);
        end
        o_haddr = haddr;   o_htrans = htrans;   o_hwrite = hwrite;
        o_hwmask = hwmask; o_hwdata = hwdata;
        o_i_ready = i_ready; o_i_rdata = i_rdata; o_i_err = i_err;
        o_d_ready = d_ready; o_d_err_rdata = d_rdata; o_d_err = d_err;
        o_gd = grant_data; o_stall = stall;
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_store = 0; m_wdata = 0;
            m_starve = 0; m_gd = 0; m_stall = 0;
        end else begin
            if (m_owner != 0 && !hready) m_stall = m_stall + 32'h1;
            if (g_d && i_req) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else if (g_i || !i_req) m_starve = 0;
            if (g_i || g_d) begin
                m_owner = g_i ? 1 : 2;
                m_store = g_d && d_wr;
                m_wdata = d_wdata;
                m_gd    = g_d;
            end else if (free) begin
                m_owner = 0;
                m_store = 0;
            end
        end
        #1;
    endtask

    int d_before_i;
    bit seen_i;

    initial begin
        rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0;
        d_addr = 0; d_wmask = 0; d_wdata = 0;
        hready = 1; hrdata = 0; hresp = 0;
        m_owner = 0; m_store = 0; m_wdata = 0;
        m_starve = 0; m_gd = 0; m_stall = 0;
        #1;
        cycle(); cycle();
        rst = 0;
        cycle();
        chk("rst_htrans", 32'(o_htrans), 32'd0);
        chk("rst_grant", 32'(o_gd), 32'd0);
        chk("rst_stall", o_stall, 32'd0);

        // single fetch
        i_req = 1; i_addr = 32'h100; hrdata = 32'h13;
        cycle();
        chk("f_htrans", 32'(o_htrans), 32'd2);
        chk("f_haddr", o_haddr, 32'h100);
        chk("f_hwrite", 32'(o_hwrite), 32'd0);
        cycle();
        chk("f_ready", 32'(o_i_ready), 32'd1);
        chk("f_rdata", o_i_rdata, 32'h13);
        chk("f_dready", 32'(o_d_ready), 32'd0);
        chk("f_noregrant", 32'(o_htrans), 32'd0);
        i_req = 0;
        cycle();

        // store with three wait states
        d_req = 1; d_wr = 1; d_addr = 32'h2004; d_wmask = 4'b0011;
        d_wdata = 32'hA5A5;
        cycle();
        chk("s_htrans", 32'(o_htrans), 32'd2);
        chk("s_hwrite", 32'(o_hwrite), 32'd1);
        chk("s_hwmask", 32'(o_hwmask), 32'd3);
        hready = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("s_wait_hwdata", o_hwdata, 32'hA5A5);
            chk("s_wait_htrans", 32'(o_htrans), 32'd0);
            chk("s_wait_ready", 32'(o_d_ready), 32'd0);
        end
        hready = 1;
        cycle();
        chk("s_hwdata", o_hwdata, 32'hA5A5);
        chk("s_ready", 32'(o_d_ready), 32'd1);
`ifdef MSRV32_ARB_PERF_EN
        chk("s_stall", o_stall, 32'd3);
`else
        chk("s_stall", o_stall, 32'd0);
`endif
        d_req = 0; d_wr = 0;
        cycle();
        chk("s_hwdata_clr", o_hwdata, 32'h0);

        // load with bus error
        d_req = 1; d_addr = 32'h3000;
        cycle();
        hresp = 1; hrdata = 32'hDEAD;
        cycle();
        chk("e_dready", 32'(o_d_ready), 32'd1);
        chk("e_derr", 32'(o_d_err), 32'd1);
        chk("e_ierr", 32'(o_i_err), 32'd0);
        d_req = 0; hresp = 0;
        cycle();

        // contention with both requests held
        i_req = 1; i_addr = 32'h400; d_req = 1; d_addr = 32'h500;
        d_before_i = 0; seen_i = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k == 0) chk("c_first_d", o_haddr, 32'h500);
            if (k == 1) chk("c_then_i", o_haddr, 32'h400);
            if (k == 2) chk("c_then_d", o_haddr, 32'h500);
            if (o_htrans == 2'b10 && o_haddr == 32'h400) seen_i = 1;
            if (!seen_i && o_htrans == 2'b10 && o_haddr == 32'h500)
                d_before_i++;
        end
        chk("c_seen_i", 32'(seen_i), 32'd1);
        tests++;
        if (d_before_i > LIMIT) begin
            fails++;
            $display("FAIL c_starve: got %0d data grants limit %0d",
                     d_before_i, LIMIT);
        end
        i_req = 0; d_req = 0;
        cycle(); cycle();

        // reset during a stalled store
        d_req = 1; d_wr = 1; d_addr = 32'h10; d_wmask = 4'hF;
        d_wdata = 32'h1234;
        cycle();
        hready = 0;
        cycle();
        rst = 1;
        cycle();
        chk("r_dready", 32'(o_d_ready), 32'd0);
        chk("r_htrans", 32'(o_htrans), 32'd0);
        rst = 0; d_req = 0; d_wr = 0; hready = 1;
        cycle();
        chk("r_htrans2", 32'(o_htrans), 32'd0);
        chk("r_hwdata", o_hwdata, 32'h0);
        chk("r_grant", 32'(o_gd), 32'd0);
        chk("r_stall", o_stall, 32'd0);
        i_req = 1; i_addr = 32'h200; hrdata = 32'h55;
        cycle();
        chk("r_fetch_haddr", o_haddr, 32'h200);
        cycle();
        chk("r_fetch_ready", 32'(o_i_ready), 32'd1);
        chk("r_fetch_rdata", o_i_rdata, 32'h55);
        i_req = 0;

        // idle bus
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("idle_htrans", 32'(o_htrans), 32'd0);
            chk("idle_grant", 32'(o_gd), 32'd0);
            chk("idle_ready", 32'(o_i_ready | o_d_ready), 32'd0);
        end

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            hready = ($urandom % 4) != 0;
            hresp  = ($urandom % 8) == 0;
            hrdata = $urandom;
            rst    = ($urandom % 600) == 0;
            cycle();
            if (o_i_ready || !i_req) begin
                i_req  = ($urandom % 3) != 0;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (o_d_ready || !d_req) begin
                d_req   = ($urandom % 2) != 0;
                d_wr    = $urandom % 2;
                d_addr  = $urandom;
                d_wmask = 4'($urandom);
                d_wdata = $urandom;
            end
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
